// File: rtl/calc_sequencer.sv
// calc_sequencer: runs N calculadora steps, then dumps registers 0..NREGS-1 as a stream.
// Build option: CALC_SEQ_SKIPZERO_EN suppresses records whose captured value is zero.
module calc_sequencer #(
    parameter int W       = 64,
    parameter int NREGS   = 32,
    parameter int STEPS_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [STEPS_W-1:0] nsteps,
    output logic               busy,
    output logic               done,
    output logic               opera,
    output logic [4:0]         read,
    input  logic [W-1:0]       data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         out_idx,
    output logic [W-1:0]       out_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_STEP, S_GAP, S_RD, S_CAP, S_HOLD, S_DONE
    } state_t;

    localparam logic [4:0] LAST = 5'(NREGS - 1);

    state_t             state_q, state_d;
    logic [STEPS_W-1:0] cnt_q, cnt_d;
    logic [4:0]         idx_q, idx_d;
    logic [4:0]         read_q, read_d;
    logic               opera_q, opera_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic [4:0]         oidx_q, oidx_d;
    logic [W-1:0]       odata_q, odata_d;
    logic               skip;

`ifdef CALC_SEQ_SKIPZERO_EN
    assign skip = (data == '0);
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        oidx_d  = oidx_q;
        odata_d = odata_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = nsteps;
                    idx_d   = '0;
                    state_d = (nsteps != '0) ? S_STEP : S_RD;
                end
            end
            S_STEP: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    state_d = S_STEP;
                end else begin
                    idx_d   = '0;
                    state_d = S_RD;
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                if (skip) begin
                    if (idx_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_RD;
                    end
                end else begin
                    odata_d = data;
                    oidx_d  = idx_q;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_RD;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Outputs are decoded from the next state so they are registered.
        opera_d = (state_d == S_STEP);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        read_d  = (state_d == S_RD) ? idx_d : read_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            read_q  <= '0;
            opera_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            oidx_q  <= '0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            read_q  <= read_d;
            opera_q <= opera_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            oidx_q  <= oidx_d;
            odata_q <= odata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign opera     = opera_q;
    assign read      = read_q;
    assign out_valid = valid_q;
    assign out_idx   = oidx_q;
    assign out_data  = odata_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a small register-file stand-in.
// Stand-in RF: reg r = 0 when r odd, else ops*(3+r); ops counts opera pulses.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  nsteps = '0;
    logic        busy, done, opera, out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  read, out_idx;
    logic [63:0] data, out_data;

    calc_sequencer dut (
        .clock(clk), .reset(rst), .start(start), .nsteps(nsteps),
        .busy(busy), .done(done), .opera(opera), .read(read),
        .data(data), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [63:0] rfval(input int r, input int o);
        return (r % 2 == 1) ? 64'd0 : 64'(o) * 64'(3 + r);
    endfunction

    logic [63:0] ops;
    always @(posedge clk) begin
        if (rst) ops <= '0;
        else if (opera) ops <= ops + 64'd1;
    end
    assign data = read[0] ? 64'd0 : ops * (64'd3 + {59'd0, read});

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          op_t[$];
    int          rec_t[$];
    int          rec_i[$];
    logic [63:0] rec_d[$];
    int          n_done = 0;
    int          stab_err = 0;
    logic        pv = 1'b0;
    logic [4:0]  p_idx, p_read;
    logic [63:0] p_data;

    always @(negedge clk) begin
        if (opera) op_t.push_back(cyc);
        if (done) n_done++;
        if (out_valid && read != out_idx) stab_err++;
        if (pv && (!out_valid || out_idx != p_idx ||
                   out_data != p_data || read != p_read)) stab_err++;
        if (out_valid && out_ready) begin
            rec_t.push_back(cyc);
            rec_i.push_back(int'(out_idx));
            rec_d.push_back(out_data);
        end
        pv     = out_valid && !out_ready;
        p_idx  = out_idx;
        p_data = out_data;
        p_read = read;
    end

    task automatic clr();
        op_t.delete();
        rec_t.delete();
        rec_i.delete();
        rec_d.delete();
        n_done   = 0;
        stab_err = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clr();
    endtask

    task automatic run(input int n);
        start  = 1'b1;
        nsteps = 8'(n);
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (n_done != 0) break;
        end
        check("done_seen", 64'(n_done != 0), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("busy_after", 64'(busy), 64'd0);
        check("done_once", 64'(n_done), 64'd1);
    endtask

    task automatic check_dump(input int o);
        int ei[$];
        int mism;
        mism = 0;
        for (int r = 0; r < 32; r++) begin
`ifdef CALC_SEQ_SKIPZERO_EN
            if (rfval(r, o) != 0) ei.push_back(r);
`else
            ei.push_back(r);
`endif
        end
        check("nrec", 64'(rec_i.size()), 64'(ei.size()));
        if (rec_i.size() == ei.size()) begin
            foreach (ei[k]) begin
                if (rec_i[k] != ei[k] || rec_d[k] != rfval(ei[k], o)) mism++;
            end
        end else mism = -1;
        check("dump", 64'(mism), 64'd0);
        check("stable", 64'(stab_err), 64'd0);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_opera", 64'(opera), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_read", 64'(read), 64'd0);
        check("rst_oidx", 64'(out_idx), 64'd0);
        check("rst_odata", out_data, 64'd0);
        rst = 1'b0;
        clr();

        // 1: one step
        run(1);
        check("s1_pulses", 64'(op_t.size()), 64'd1);
        check("s1_idx0", rec_d.size() > 0 ? rec_d[0] : 64'hx, 64'd3);
        check_dump(1);
`ifndef CALC_SEQ_SKIPZERO_EN
        check("s1_rate", rec_t.size() == 32 ? 64'(rec_t[31] - rec_t[0]) : 64'hx,
              64'd93);
        check("s1_idx2", rec_d.size() > 2 ? rec_d[2] : 64'hx, 64'd5);
`endif

        // 2: three steps
        do_reset();
        run(3);
        check("s2_pulses", 64'(op_t.size()), 64'd3);
        check("s2_gap01", op_t.size() == 3 ? 64'(op_t[1] - op_t[0]) : 64'hx, 64'd2);
        check("s2_gap12", op_t.size() == 3 ? 64'(op_t[2] - op_t[1]) : 64'hx, 64'd2);
        check("s2_idx0", rec_d.size() > 0 ? rec_d[0] : 64'hx, 64'd9);
        check_dump(3);

        // 3: sixteen steps
        do_reset();
        run(16);
        check("s3_pulses", 64'(op_t.size()), 64'd16);
        check("s3_span", op_t.size() == 16 ? 64'(op_t[15] - op_t[0]) : 64'hx, 64'd30);
        check("s3_idx0", rec_d.size() > 0 ? rec_d[0] : 64'hx, 64'd48);
`ifndef CALC_SEQ_SKIPZERO_EN
        check("s3_idx5", rec_d.size() == 32 ? rec_d[5] : 64'hx, 64'd0);
        check("s3_idx6", rec_d.size() == 32 ? rec_d[6] : 64'hx, 64'd144);
        check("s3_idx10", rec_d.size() == 32 ? rec_d[10] : 64'hx, 64'd208);
`endif
        check_dump(16);

        // 4: zero steps, dump straight away
        do_reset();
        run(0);
        check("s4_pulses", 64'(op_t.size()), 64'd0);
`ifdef CALC_SEQ_SKIPZERO_EN
        check("s4_nrec", 64'(rec_i.size()), 64'd0);
`else
        check("s4_idx0", rec_d.size() > 0 ? rec_d[0] : 64'hx, 64'd0);
        check("s4_rate", rec_t.size() == 32 ? 64'(rec_t[31] - rec_t[0]) : 64'hx,
              64'd93);
`endif
        check_dump(0);

        // 5: back-pressure on idx2
        do_reset();
        fork
            run(1);
            begin
                for (int i = 0; i < 500; i++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid && out_idx == 5'd2) break;
                end
                out_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check_dump(1);
        begin
            int p;
`ifdef CALC_SEQ_SKIPZERO_EN
            p = 1;
`else
            p = 2;
`endif
            check("s5_idx2", rec_d.size() > p ? rec_d[p] : 64'hx, 64'd5);
            check("s5_stall", rec_t.size() > p ? 64'(rec_t[p] - rec_t[p-1] >= 12)
                  : 64'hx, 64'd1);
        end

        // 6: reset during step 2 of 5
        do_reset();
        start  = 1'b1;
        nsteps = 8'd5;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (opera && op_t.size() == 1) break;
        end
        check("s6_in_step2", 64'(opera && op_t.size() == 1), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("s6_opera", 64'(opera), 64'd0);
        check("s6_busy", 64'(busy), 64'd0);
        check("s6_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        clr();
        run(1);
        check("s6_idx0", rec_d.size() > 0 ? rec_d[0] : 64'hx, 64'd3);
        check_dump(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
